button_debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for active-low mechanical push-buttons on the 10 MHz system clock. Each channel synchronises its raw input, requires a configurable stable interval before accepting a level change, and produces a debounced level plus single-cycle press, release, long-press and auto-repeat pulses. It sits between the board button pins and the I2C EEPROM master control logic, and replaces single-button, press-only debouncing.

---
 rtl/button_debounce_multi_pkg.sv | 26 ++
 rtl/button_debounce_multi_if.sv | 25 ++
 rtl/button_debounce_multi_ch.sv | 109 ++++++++++
 rtl/button_debounce_multi.sv | 47 ++++
 tb/tb_button_debounce_multi.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_multi_pkg.sv
// Shared definitions for the multi-channel push-button debouncer:
// default parameter values, a width helper and the idle pin level.
package button_pkg;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_ACTIVE_LOW      = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 200000;
    localparam int DEF_LONG_CYCLES     = 10000000;
    localparam int DEF_REPEAT_CYCLES   = 2000000;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Pin level of a released button: high for active-low wiring.
    function automatic logic IDLE_LEVEL(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/button_debounce_multi_if.sv
// Button pins in, debounced level and event pulses out, one bit per channel.
interface button_debounce_multi_if
    import button_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    logic [N_CH-1:0] i_Btn;
    logic [N_CH-1:0] o_Pressed;
    logic [N_CH-1:0] o_Press_Pulse;
    logic [N_CH-1:0] o_Release_Pulse;
    logic [N_CH-1:0] o_Long_Pulse;
    logic [N_CH-1:0] o_Repeat_Pulse;

    // Board side: drives the pins, consumes the debounced events.
    modport master (
        output i_Btn,
        input  o_Pressed, o_Press_Pulse, o_Release_Pulse, o_Long_Pulse, o_Repeat_Pulse
    );

    // Debouncer side.
    modport slave (
        input  i_Btn,
        output o_Pressed, o_Press_Pulse, o_Release_Pulse, o_Long_Pulse, o_Repeat_Pulse
    );
endinterface

// File: rtl/button_debounce_multi_ch.sv
// One debounced button channel: 2-flop synchroniser, stability counter,
// level register, hold counter and single-cycle event pulses.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic IDLE   = IDLE_LEVEL(ACTIVE_LOW);
    localparam int   STAB_W = clog2(DEBOUNCE_CYCLES) + 1;
    localparam int   HOLD_W = clog2(LONG_CYCLES + REPEAT_CYCLES) + 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_AT   = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(LONG_CYCLES + REPEAT_CYCLES - 1);

    logic              sync_1;
    logic              sync_2;
    logic              sample;
    logic              mismatch;
    logic              accept;
    logic              rise;
    logic              fall;
    logic [STAB_W-1:0] stab_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Two-stage synchroniser, reset to the released pin level.
    // NOTE: every clocked assignment uses <= so sync_2 takes the old sync_1;
    // with = the two flops would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= IDLE;
            sync_2 <= IDLE;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Normalise polarity so 1 always means pressed.
    assign sample   = sync_2 ^ IDLE;
    assign mismatch = (sample != pressed);
    assign accept   = mismatch && (stab_cnt == STAB_LAST);
    assign rise     = accept && !pressed;
    assign fall     = accept && pressed;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !mismatch || accept) begin
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Accepted level and its press/release edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= rise;
            release_pulse <= fall;
            if (accept) begin
                pressed <= ~pressed;
            end
        end
    end

    // Hold timer: long pulse at LONG_CYCLES, then a repeat every
    // REPEAT_CYCLES by folding the count back to LONG_CYCLES; with repeat
    // disabled it parks at LONG_CYCLES. A release on the same edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt     <= '0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            if (!pressed || fall) begin
                hold_cnt <= '0;
            end else if (hold_cnt == LONG_LAST) begin
                hold_cnt   <= hold_cnt + 1'b1;
                long_pulse <= 1'b1;
            end else if ((REPEAT_CYCLES != 0) && (hold_cnt == REP_LAST)) begin
                hold_cnt     <= LONG_AT;
                repeat_pulse <= 1'b1;
            end else if ((REPEAT_CYCLES != 0) || (hold_cnt != LONG_AT)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer: N_CH independent channels, the top
// level only slices the per-channel bits out of the interface vectors.
module button_debounce_multi
    import button_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                    i_Clock10MHz,
    input  logic                    i_Rst,
    button_debounce_multi_if.slave  bus
);

    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (i_Clock10MHz),
            .rst           (i_Rst),
            .btn           (bus.i_Btn[g]),
            .pressed       (pressed[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_pulse    (long_pulse[g]),
            .repeat_pulse  (repeat_pulse[g])
        );
    end

    assign bus.o_Pressed       = pressed;
    assign bus.o_Press_Pulse   = press_pulse;
    assign bus.o_Release_Pulse = release_pulse;
    assign bus.o_Long_Pulse    = long_pulse;
    assign bus.o_Repeat_Pulse  = repeat_pulse;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: expected pulse events are queued
// with their edge number as stimulus is applied and matched as pulses appear.
`timescale 1ns/1ps
module tb_button_debounce_multi;

    localparam int N    = 2;
    localparam int DEB  = 8;
    localparam int LONG = 40;
    localparam int REP  = 10;
    localparam int LAT  = DEB + 2;  // drive at negedge n -> event at edge n+LAT

    typedef struct {
        int         at;
        logic [7:0] pulses;  // {press, release, long, repeat}
        string      tag;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    int   nr_long = 0;
    int   nr_rep = 0;
    int   nr_long_at = -1;

    always #50 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    button_debounce_multi_if #(.N_CH(N)) bus ();
    button_debounce_multi_if #(.N_CH(N)) bus_nr ();

    button_debounce_multi #(
        .N_CH(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .i_Clock10MHz (clk),
        .i_Rst        (rst),
        .bus          (bus)
    );

    button_debounce_multi #(
        .N_CH(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)
    ) dut_nr (
        .i_Clock10MHz (clk),
        .i_Rst        (rst),
        .bus          (bus_nr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input logic [1:0] rp, input string tag);
        ev_t ev;
        ev.at     = at;
        ev.pulses = {p, r, l, rp};
        ev.tag    = tag;
        exp_q.push_back(ev);
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Scoreboard: every pulse must match the head of the queue in edge and value.
    logic [7:0] mon_seen;
    ev_t        mon_ev;
    always @(negedge clk) begin
        mon_seen = {bus.o_Press_Pulse, bus.o_Release_Pulse, bus.o_Long_Pulse, bus.o_Repeat_Pulse};
        while (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
            mon_ev = exp_q.pop_front();
            check({mon_ev.tag, " missing, now at edge"}, 32'(edge_n), 32'(mon_ev.at));
        end
        if (mon_seen != 8'h0) begin
            if (exp_q.size() == 0) begin
                check("unexpected pulse", 32'(mon_seen), 32'h0);
            end else begin
                mon_ev = exp_q.pop_front();
                check({mon_ev.tag, " edge"}, 32'(edge_n), 32'(mon_ev.at));
                check({mon_ev.tag, " pulses"}, 32'(mon_seen), 32'(mon_ev.pulses));
            end
        end
    end

    // Event tally for the repeat-disabled build.
    always @(negedge clk) begin
        if (bus_nr.o_Long_Pulse[0]) begin
            nr_long++;
            nr_long_at = edge_n;
        end
        if (bus_nr.o_Repeat_Pulse != 2'b00) nr_rep++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        int t;
        int p;
        bus.i_Btn    = 2'b00;
        bus_nr.i_Btn = 2'b11;
        rst          = 1'b1;

        // Reset with both buttons held.
        repeat (3) @(negedge clk);
        check("reset pressed", 32'(bus.o_Pressed), 32'h0);
        check("reset press_pulse", 32'(bus.o_Press_Pulse), 32'h0);
        check("reset release_pulse", 32'(bus.o_Release_Pulse), 32'h0);
        check("reset long_pulse", 32'(bus.o_Long_Pulse), 32'h0);
        check("reset repeat_pulse", 32'(bus.o_Repeat_Pulse), 32'h0);
        rst = 1'b0;
        t = edge_n;
        expect_ev(t + LAT, 2'b11, 2'b00, 2'b00, 2'b00, "held-through-reset press");
        wait_to(t + LAT - 1);
        check("held press not early", 32'(bus.o_Pressed), 32'h0);
        wait_to(t + LAT);
        check("held press level", 32'(bus.o_Pressed), 32'h3);
        bus.i_Btn = 2'b11;
        t = edge_n;
        expect_ev(t + LAT, 2'b00, 2'b11, 2'b00, 2'b00, "both release");
        wait_to(t + LAT);
        check("both released level", 32'(bus.o_Pressed), 32'h0);

        // Glitch on ch0 after 5 low samples restarts the debounce count.
        t = edge_n;
        bus.i_Btn[0] = 1'b0;
        wait_to(t + 5);
        bus.i_Btn[0] = 1'b1;
        wait_to(t + 6);
        bus.i_Btn[0] = 1'b0;
        expect_ev(t + 6 + LAT, 2'b01, 2'b00, 2'b00, 2'b00, "post-glitch press");
        wait_to(t + 6 + LAT - 1);
        check("glitch press not early", 32'(bus.o_Pressed), 32'h0);
        wait_to(t + 6 + LAT);
        check("glitch press level", 32'(bus.o_Pressed), 32'h1);
        bus.i_Btn[0] = 1'b1;
        t = edge_n;
        expect_ev(t + LAT, 2'b00, 2'b01, 2'b00, 2'b00, "post-glitch release");
        wait_to(t + LAT);

        // Long hold on ch0: long, four repeats, release suppresses the fifth.
        t = edge_n;
        bus.i_Btn[0] = 1'b0;
        p = t + LAT;
        expect_ev(p, 2'b01, 2'b00, 2'b00, 2'b00, "hold press");
        expect_ev(p + LONG, 2'b00, 2'b00, 2'b01, 2'b00, "long");
        for (int k = 1; k <= 4; k++) begin
            expect_ev(p + LONG + k * REP, 2'b00, 2'b00, 2'b00, 2'b01, $sformatf("repeat %0d", k));
        end
        wait_to(p + 80);
        check("hold level", 32'(bus.o_Pressed), 32'h1);
        bus.i_Btn[0] = 1'b1;
        expect_ev(p + 80 + LAT, 2'b00, 2'b01, 2'b00, 2'b00, "release over repeat");
        wait_to(p + 80 + LAT);
        check("hold released level", 32'(bus.o_Pressed), 32'h0);

        // Release landing on the long-press edge: release only.
        t = edge_n;
        bus.i_Btn[0] = 1'b0;
        p = t + LAT;
        expect_ev(p, 2'b01, 2'b00, 2'b00, 2'b00, "short press");
        wait_to(p + LONG - LAT);
        bus.i_Btn[0] = 1'b1;
        expect_ev(p + LONG, 2'b00, 2'b01, 2'b00, 2'b00, "release over long");
        wait_to(p + LONG);
        check("release over long level", 32'(bus.o_Pressed), 32'h0);
        wait_to(p + LONG + 5);

        // Reset while ch1 pressed: no release pulse, full re-debounce.
        t = edge_n;
        bus.i_Btn[1] = 1'b0;
        p = t + LAT;
        expect_ev(p, 2'b10, 2'b00, 2'b00, 2'b00, "ch1 press");
        wait_to(p + 5);
        rst = 1'b1;
        wait_to(p + 6);
        check("mid-press reset level", 32'(bus.o_Pressed), 32'h0);
        rst = 1'b0;
        t = edge_n;
        expect_ev(t + LAT, 2'b10, 2'b00, 2'b00, 2'b00, "ch1 re-press");
        wait_to(t + LAT - 1);
        check("re-press not early", 32'(bus.o_Pressed), 32'h0);
        wait_to(t + LAT);
        check("re-press level", 32'(bus.o_Pressed), 32'h2);
        bus.i_Btn[1] = 1'b1;
        t = edge_n;
        expect_ev(t + LAT, 2'b00, 2'b10, 2'b00, 2'b00, "ch1 release");
        wait_to(t + LAT);

        // Repeat-disabled build: one long pulse, no repeats over a 200-cycle hold.
        t = edge_n;
        bus_nr.i_Btn[0] = 1'b0;
        wait_to(t + 200);
        check("no-repeat held level", 32'(bus_nr.o_Pressed), 32'h1);
        check("no-repeat long count", 32'(nr_long), 32'd1);
        check("no-repeat long edge", 32'(nr_long_at), 32'(t + LAT + LONG));
        check("no-repeat repeat count", 32'(nr_rep), 32'd0);
        bus_nr.i_Btn[0] = 1'b1;
        t = edge_n;
        wait_to(t + LAT);
        check("no-repeat released level", 32'(bus_nr.o_Pressed), 32'h0);

        wait_to(edge_n + 3);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
